// File: rtl/bcd7seg_scan_mux.sv
// Time-multiplexed BCD-to-7-segment driver: double-buffered digits, blank-slot scan FSM, runtime polarity.
// Optional leading-zero blanking (adds port blank_lz) when BCD7SEG_LZ_BLANK_EN is defined.
module bcd7seg_scan_mux #(
    parameter int N_DIGITS = 4,
    parameter int SCAN_DIV = 1000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*N_DIGITS-1:0] bcd,
    input  logic                  load,
    input  logic                  common_cathode,
`ifdef BCD7SEG_LZ_BLANK_EN
    input  logic                  blank_lz,
`endif
    output logic [6:0]            seg,
    output logic [N_DIGITS-1:0]   dig_en,
    output logic                  frame_done
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

    typedef enum logic {BLANK, ON} state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [4*N_DIGITS-1:0] pend_q, disp_q;
    logic                  copy;

    logic [3:0]            cur_digit;
    logic                  cur_blank;
    logic [6:0]            seg_d;
    logic [N_DIGITS-1:0]   en_d;
    logic                  fd_d;

    logic [6:0]            seg_p1;
    logic [N_DIGITS-1:0]   en_p1;
    logic                  fd_p1;

    function automatic logic [6:0] dec7(input logic [3:0] v);
        case (v)
            4'd0:    dec7 = 7'b1111110;
            4'd1:    dec7 = 7'b0110000;
            4'd2:    dec7 = 7'b1101101;
            4'd3:    dec7 = 7'b1111001;
            4'd4:    dec7 = 7'b0110011;
            4'd5:    dec7 = 7'b1011011;
            4'd6:    dec7 = 7'b1011111;
            4'd7:    dec7 = 7'b1110000;
            4'd8:    dec7 = 7'b1111111;
            4'd9:    dec7 = 7'b1111011;
            default: dec7 = 7'b0000001;
        endcase
    endfunction

    // Scan FSM next state; the pending buffer is promoted when leaving the digit-0 blank slot.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        copy    = 1'b0;
        case (state_q)
            BLANK: begin
                state_d = ON;
                cnt_d   = '0;
                copy    = (idx_q == '0);
            end
            ON: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = BLANK;
                    cnt_d   = '0;
                    idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = BLANK;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BLANK;
            cnt_q   <= '0;
            idx_q   <= '0;
            pend_q  <= '0;
            disp_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            if (load) pend_q <= bcd;
            if (copy) disp_q <= pend_q;
        end
    end

    // Digit select, optional leading-zero suppression and decode for the current slot.
    always_comb begin
        logic lead_zero;
        logic [N_DIGITS-1:0] lz;
        cur_digit = '0;
        cur_blank = 1'b0;
        lz        = '0;
        lead_zero = 1'b1;
        for (int i = N_DIGITS - 1; i >= 1; i--) begin
            lead_zero = lead_zero && (disp_q[4*i +: 4] == 4'd0);
            lz[i]     = lead_zero;
        end
        en_d = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_digit = disp_q[4*i +: 4];
`ifdef BCD7SEG_LZ_BLANK_EN
                cur_blank = blank_lz && lz[i];
`else
                cur_blank = 1'b0;
`endif
                en_d[i]   = (state_q == ON);
            end
        end
        seg_d = (state_q == ON && !cur_blank) ? dec7(cur_digit) : 7'b0000000;
        fd_d  = (state_q == ON) && (cnt_q == CNT_LAST) && (idx_q == IDX_LAST);
    end

    // Output register stage (active-high internally).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_p1 <= '0;
            en_p1  <= '0;
            fd_p1  <= 1'b0;
        end else begin
            seg_p1 <= seg_d;
            en_p1  <= en_d;
            fd_p1  <= fd_d;
        end
    end

    assign seg        = seg_p1 ~^ {7{common_cathode}};
    assign dig_en     = en_p1 ~^ {N_DIGITS{common_cathode}};
    assign frame_done = fd_p1;

endmodule

// File: tb/tb_bcd7seg_scan_mux.sv
// Scoreboard bench for bcd7seg_scan_mux: a frame-position model queues expected outputs, a monitor checks them.
module tb_bcd7seg_scan_mux;
    localparam int N = 4;
    localparam int S = 4;
    localparam int P = N * (S + 1);
    localparam logic [6:0] PAT [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011, 7'b1011011, 7'b1011111,
        7'b1110000, 7'b1111111, 7'b1111011, 7'b0000001, 7'b0000001, 7'b0000001, 7'b0000001,
        7'b0000001, 7'b0000001};

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [15:0]   bcd = '0;
    logic          load = 1'b0;
    logic          cc = 1'b1;
`ifdef BCD7SEG_LZ_BLANK_EN
    logic          blank_lz = 1'b0;
`endif
    logic [6:0]    seg;
    logic [N-1:0]  dig_en;
    logic          frame_done;

    always #5 clk = ~clk;

    bcd7seg_scan_mux #(.N_DIGITS(N), .SCAN_DIV(S)) dut (
        .clk(clk), .rst_n(rst_n), .bcd(bcd), .load(load), .common_cathode(cc),
`ifdef BCD7SEG_LZ_BLANK_EN
        .blank_lz(blank_lz),
`endif
        .seg(seg), .dig_en(dig_en), .frame_done(frame_done));

    typedef struct packed {
        logic [6:0]   s;
        logic [N-1:0] e;
        logic         f;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;

    task automatic chk(input string name, input logic [11:0] act, input logic [11:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s at %0t: actual seg/en/fd=%b_%b_%b required=%b_%b_%b", name, $time,
                     act[11:5], act[4:1], act[0], req[11:5], req[4:1], req[0]);
        end
    endtask

    function automatic logic [11:0] off_val(input logic c);
        return {{7{~c}}, {N{~c}}, 1'b0};
    endfunction

    // Reference model: output cycle k after reset release sits at position k mod P of a frame;
    // each frame shows the pending value that existed just before its first edge.
    int          k;
    logic [15:0] m_pend, m_disp;
    int          q, d, r;
    exp_t        e;
    always @(posedge clk) begin
        if (!rst_n) begin
            k = 0; m_pend = '0; m_disp = '0;
            exp_q.delete();
        end else begin
            if (k % P == 0) m_disp = m_pend;
            q = k % P; d = q / (S + 1); r = q % (S + 1);
            e = '0;
            if (r != 0) begin
                e.e = N'(1 << d);
                e.s = PAT[m_disp[4*d +: 4]];
`ifdef BCD7SEG_LZ_BLANK_EN
                if (blank_lz && d > 0 && (m_disp >> (4 * d)) == 16'd0) e.s = '0;
`endif
            end
            e.f = (d == N - 1) && (r == S);
            exp_q.push_back(e);
            k++;
            if (load) m_pend = bcd;
        end
    end

    // Monitor: one output per cycle, checked just after the edge.
    always @(posedge clk) begin
        exp_t x;
        #1;
        if (!rst_n) begin
            chk("reset_off", {seg, dig_en, frame_done}, off_val(cc));
        end else if (exp_q.size() == 0) begin
            chk("queue_empty", 12'h000, 12'hFFF);
        end else begin
            x = exp_q.pop_front();
            chk("scan", {seg, dig_en, frame_done},
                {cc ? x.s : ~x.s, cc ? x.e : ~x.e, x.f});
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_load(input logic [15:0] v);
        bcd = v; load = 1'b1;
        cyc(1);
        load = 1'b0;
    endtask

    initial begin
        bit found;
        cyc(3);
        cc = 1'b0;
        #1 chk("rst_polarity_cc0", {seg, dig_en, frame_done}, off_val(1'b0));
        cyc(2);
        cc = 1'b1;
        rst_n = 1'b1;
        do_load(16'h1234);
        cyc(45);
        cyc(7);
        do_load(16'h1234);
        cyc(3);
        do_load(16'h9999);
        cyc(45);
        do_load(16'h00AF);
        cyc(45);
        cc = 1'b0;
        do_load(16'h5678);
        cyc(25);
        cc = 1'b1;
`ifdef BCD7SEG_LZ_BLANK_EN
        blank_lz = 1'b1;
        do_load(16'h0050);
        cyc(45);
        do_load(16'h0000);
        cyc(45);
        do_load(16'h0A00);
        cyc(45);
        blank_lz = 1'b0;
`endif
        for (int i = 0; i < 400; i++) begin
            bcd  = 16'($urandom);
            load = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 30) == 0) cc = ~cc;
`ifdef BCD7SEG_LZ_BLANK_EN
            if ($urandom_range(0, 30) == 0) blank_lz = ~blank_lz;
`endif
            cyc(1);
        end
        load = 1'b0;
        cc = 1'b1;
        // Align to the start of a frame, then hit reset in the middle of digit 2's slot.
        found = 1'b0;
        for (int i = 0; i < 2 * P && !found; i++) begin
            cyc(1);
            found = frame_done;
        end
        chk("frame_done_seen", {11'd0, found}, 12'd1);
        do_load(16'h4321);
        cyc(11);
        chk("pre_reset_digit2_en", {7'd0, dig_en, 1'b0}, {7'd0, 4'b0100, 1'b0});
        #2 rst_n = 1'b0;
        #1 chk("async_reset_off", {seg, dig_en, frame_done}, off_val(cc));
        cyc(3);
        rst_n = 1'b1;
        cyc(45);
        cyc(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
